approx_prod_accum: RTL and testbench

- Sequential stage directly downstream of the 8x8 approximate multiplier.
- Consumes the multiplier's 16-bit product stream through a valid/ready handshake.
- Accumulates products over a packet delimited by in_last.
- Presents the packet sum, beat count and an overflow flag on an output valid/ready port. Used for dot-product and error-statistics runs on the approximate multipliers.

---
 rtl/approx_prod_accum.sv | 94 +++++++++
 tb/tb_approx_prod_accum.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_prod_accum.sv
// Packet accumulator behind the approximate multiplier: sums products per packet, reports sum/count/overflow.
// Latency: result valid one cycle after the last beat is accepted. One bubble per packet on the input side.
// Backpressure: result held while out_ready=0; in_ready stays low until the result is taken.
module approx_prod_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [ACC_W:0]     sum;
    logic               accept;

    // rst_n is folded in so the source sees not-ready the instant reset asserts.
    assign in_ready = rst_n && (state_q == ST_ACC) && !clr;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        ovf_d = ovf_q | sum[ACC_W];
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (clr) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                    end else if (accept) begin
                        if (in_last) begin
                            out_acc   <= acc_d;
                            out_cnt   <= cnt_d;
                            out_ovf   <= ovf_d;
                            out_valid <= 1'b1;
                            state_q   <= ST_HOLD;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            ovf_q     <= 1'b0;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            ovf_q <= ovf_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_prod_accum.sv
// Scoreboard bench for approx_prod_accum: reference model pushes expected packet results, monitor pops on handshake.
module tb_approx_prod_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_acc;
    logic [7:0]  out_cnt;
    logic        out_ovf;

    typedef struct packed {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    res_t        exp_q[$];
    int          errs = 0;
    int          checks = 0;
    longint      m_acc = 0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    approx_prod_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [15:0] p, input bit last);
        int n = 0;
        res_t r;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            m_acc = m_acc + p;
            if (m_acc > 64'hFF_FFFF) begin
                m_acc = 64'hFF_FFFF;
                m_ovf = 1'b1;
            end
            if (m_cnt < 255) m_cnt++;
            if (last) begin
                r.acc = m_acc[23:0];
                r.cnt = m_cnt[7:0];
                r.ovf = m_ovf;
                exp_q.push_back(r);
                model_clear();
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_acc", out_acc, e.acc);
                chk("out_cnt", out_cnt, e.cnt);
                chk("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic packet and latency
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b1);
        chk("basic_valid_lat", out_valid, 1);
        chk("basic_acc_direct", out_acc, 600);
        chk("basic_ready_hold", in_ready, 0);
        @(negedge clk);
        chk("basic_ready_back", in_ready, 1);

        // single beat, max product
        send(16'hFFFF, 1'b1);
        @(negedge clk);

        // saturation of both sum and count
        for (int i = 0; i < 299; i++) send(16'hFFFF, 1'b0);
        send(16'hFFFF, 1'b1);
        @(negedge clk);

        // backpressure: result held, no beat accepted
        out_ready = 1'b0;
        send(16'd5, 1'b0);
        send(16'd6, 1'b1);
        in_valid = 1'b1;
        in_prod  = 16'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_acc", out_acc, 11);
            chk("bp_cnt", out_cnt, 2);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(16'd9, 1'b1);
        @(negedge clk);

        // clear mid-packet
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'd70;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        send(16'd70, 1'b0);
        send(16'd5, 1'b1);
        @(negedge clk);

        // a few random packets
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++)
                send(16'($urandom_range(0, 65535)), (b == len - 1));
            @(negedge clk);
        end

        // async reset mid-packet
        send(16'd40, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_acc", out_acc, 0);
        chk("arst_out_cnt", out_cnt, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd7, 1'b1);
        @(negedge clk);

        // async reset while a result is held
        out_ready = 1'b0;
        send(16'd8, 1'b1);
        chk("hold_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("hold_arst_valid", out_valid, 0);
        chk("hold_arst_acc", out_acc, 0);
        chk("hold_arst_ovf", out_ovf, 0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'd3, 1'b0);
        send(16'd4, 1'b1);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
